// File: rtl/adapter_ppfifo_2_axi_stream_if.sv
// Bundle of PPFIFO read-port and AXI Stream master signals for the adapter.
// master = adapter side, slave = PPFIFO controller / AXIS sink side.
interface adapter_ppfifo_2_axi_stream_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
  logic                    o_ppfifo_clk;
  logic                    i_ppfifo_rdy;
  logic                    o_ppfifo_act;
  logic [23:0]             i_ppfifo_size;
  logic [DATA_WIDTH:0]     i_ppfifo_data;
  logic                    o_ppfifo_stb;
  logic                    o_axi_valid;
  logic                    i_axi_ready;
  logic [DATA_WIDTH-1:0]   o_axi_data;
  logic [STROBE_WIDTH-1:0] o_axi_keep;
  logic                    o_axi_last;

  modport master (
    output o_ppfifo_clk, o_ppfifo_act, o_ppfifo_stb,
    output o_axi_valid, o_axi_data, o_axi_keep, o_axi_last,
    input  i_ppfifo_rdy, i_ppfifo_size, i_ppfifo_data, i_axi_ready
  );

  modport slave (
    input  o_ppfifo_clk, o_ppfifo_act, o_ppfifo_stb,
    input  o_axi_valid, o_axi_data, o_axi_keep, o_axi_last,
    output i_ppfifo_rdy, i_ppfifo_size, i_ppfifo_data, i_axi_ready
  );
endinterface

// File: rtl/adapter_ppfifo_2_axi_stream.sv
// Drains a Ping Pong FIFO read block and presents it as an AXI Stream master.
// Optional macro PPFIFO_AXIS_BLOCK_LAST_EN forces TLAST on the final word of each block.
//
// state     | meaning
// S_IDLE    | waiting for a filled block (i_ppfifo_rdy)
// S_ACTIVE  | block owned, popping words into the output register
// S_RELEASE | block handed back, act low for one cycle
module adapter_ppfifo_2_axi_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           i_axi_clk,
  input  logic                           rst,
  adapter_ppfifo_2_axi_stream_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_act;
  logic                  w_act_nxt;
  logic [23:0]           r_count;
  logic [23:0]           w_count_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  r_last;
  logic                  w_last_nxt;

  logic                  w_more;
  logic                  w_room;
  logic                  w_stb;
  logic                  w_blk_end;

  assign w_more = (r_count < bus.i_ppfifo_size);
  assign w_room = !r_valid || bus.i_axi_ready;
  assign w_stb  = r_act && (r_state == S_ACTIVE) && w_more && w_room;

`ifdef PPFIFO_AXIS_BLOCK_LAST_EN
  assign w_blk_end = ((r_count + 24'd1) == bus.i_ppfifo_size);
`else
  assign w_blk_end = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_act_nxt   = r_act;
    w_count_nxt = r_count;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;

    case (r_state)
      S_IDLE: begin
        if (bus.i_ppfifo_rdy) begin
          w_act_nxt   = 1'b1;
          w_count_nxt = 24'd0;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_stb) begin
          w_count_nxt = r_count + 24'd1;
        end
        // act falls on entry to RELEASE so a size-0 block holds act for one cycle
        if (!w_more) begin
          w_act_nxt   = 1'b0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_act_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_act_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // output register drains independently of the block state
    if (w_stb) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = bus.i_ppfifo_data[DATA_WIDTH-1:0];
      w_last_nxt  = bus.i_ppfifo_data[DATA_WIDTH] | w_blk_end;
    end else if (r_valid && bus.i_axi_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_act   <= 1'b0;
      r_count <= 24'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_act   <= w_act_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign bus.o_ppfifo_clk = i_axi_clk;
  assign bus.o_ppfifo_act = r_act;
  assign bus.o_ppfifo_stb = w_stb;
  assign bus.o_axi_valid  = r_valid;
  assign bus.o_axi_data   = r_data;
  assign bus.o_axi_last   = r_last;
  assign bus.o_axi_keep   = {STROBE_WIDTH{1'b1}};

endmodule
